// File: rtl/mrd_rd_addr_ctrl.sv
// mrd_rd_addr_ctrl: read-side sequencer of the mixed-radix (2/3/4/5) DFT engine.
// Each stage issues one butterfly per cycle (element banks/addresses and
// twiddle ratio). It also drives the ping-pong memory select sw.
// Optional build macro MRD_RD_HOLD_EN adds the rd_hold stall input.
// Handshake: rd_valid is high for exactly one cycle per butterfly. The bank,
// address, twiddle and factor outputs are meaningful only while rd_valid is
// high. There is no ready input; only rd_hold, when built in, can pause issue.
`timescale 1ns/1ps
module mrd_rd_addr_ctrl #(
    parameter int MAX_STG = 6,
    parameter int NW      = 11,
    parameter int AW      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NW-1:0]         n_cfg,
    input  logic [2:0]            num_stg,
    input  logic [MAX_STG*3-1:0]  factor_cfg,
    input  logic [MAX_STG*NW-1:0] stride_cfg,
    input  logic                  wr_done,
`ifdef MRD_RD_HOLD_EN
    input  logic                  rd_hold,
`endif
    output logic                  sw,
    output logic                  rd_valid,
    output logic [2:0]            rd_factor,
    output logic [14:0]           rd_bank_index,
    output logic [5*AW-1:0]       rd_bank_addr,
    output logic [NW-1:0]         rd_twdl_numrtr,
    output logic [NW:0]           rd_twdl_demontr,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_WR = 2'd2, SETUP = 2'd3} state_t;

    localparam logic [NW-1:0] ONE  = NW'(1);
    localparam logic [NW-1:0] FIVE = NW'(5);

    state_t state, state_nxt;
    logic   do_load, do_step, stage_adv, finish, hold;

    // Configuration captured when start is accepted
    logic [NW-1:0]         n_q;
    logic [2:0]            last_stg, stg;
    logic [MAX_STG*3-1:0]  fac_q;
    logic [MAX_STG*NW-1:0] str_q;

    // Current stage parameters and the butterfly to be issued next
    logic [2:0]    cur_p;
    logic [NW-1:0] cur_s;
    logic [NW:0]   cur_sp;
    logic [NW-1:0] nb_e0, nb_k, cnt;

    logic [2:0]      ld_p, src_p;
    logic [NW-1:0]   ld_s, src_s, src_e0, src_k, lane_e, adv_e0, adv_k;
    logic [NW:0]     ld_sp, src_sp;
    logic [14:0]     lane_idx;
    logic [5*AW-1:0] lane_addr;
    logic            wrap;

`ifdef MRD_RD_HOLD_EN
    assign hold = rd_hold;
`else
    assign hold = 1'b0;
`endif

    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and issue/stage-advance strobes
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_step   = 1'b0;
        stage_adv = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    do_load   = 1'b1;
                end
            end
            ISSUE: begin
                // cnt counts elements already presented; once it reaches N
                // the final butterfly is on the outputs and issue stops.
                if (cnt == n_q) state_nxt = WAIT_WR;
                else if (!hold) do_step = 1'b1;
            end
            WAIT_WR: begin
                if (wr_done) begin
                    if (stg == last_stg) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = SETUP;
                        stage_adv = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_nxt = ISSUE;
                do_load   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly generation: pick the stage's first butterfly on a load, else
    // the pending one. Expand its lanes and compute the successor.
    always_comb begin
        if (state == IDLE) begin
            ld_p = factor_cfg[2:0];
            ld_s = stride_cfg[NW-1:0];
        end else begin
            ld_p = fac_q[3*stg +: 3];
            ld_s = str_q[NW*stg +: NW];
        end
        ld_sp = {1'b0, ld_s} * {{(NW-2){1'b0}}, ld_p};

        if (do_load) begin
            src_p  = ld_p;
            src_s  = ld_s;
            src_sp = ld_sp;
            src_e0 = '0;
            src_k  = '0;
        end else begin
            src_p  = cur_p;
            src_s  = cur_s;
            src_sp = cur_sp;
            src_e0 = nb_e0;
            src_k  = nb_k;
        end

        lane_idx  = '0;
        lane_addr = '0;
        lane_e    = src_e0;
        for (int j = 0; j < 5; j++) begin
            if (3'(j) < src_p) begin
                lane_idx[3*j +: 3]   = 3'(lane_e % FIVE);
                lane_addr[AW*j +: AW] = AW'(lane_e / FIVE);
            end
            lane_e = lane_e + src_s;
        end

        // k runs fastest; wrapping k moves e0 to the next group base g*S*p.
        wrap   = (src_k == src_s - ONE);
        adv_k  = wrap ? '0 : src_k + ONE;
        adv_e0 = wrap ? src_e0 + NW'(src_sp) - src_s + ONE : src_e0 + ONE;
    end

    // Configuration latch, stage index and issue counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q      <= '0;
            last_stg <= '0;
            fac_q    <= '0;
            str_q    <= '0;
            stg      <= '0;
            cur_p    <= '0;
            cur_s    <= '0;
            cur_sp   <= '0;
            nb_e0    <= '0;
            nb_k     <= '0;
            cnt      <= '0;
        end else begin
            if (state == IDLE && start) begin
                n_q      <= n_cfg;
                last_stg <= (num_stg == 3'd0) ? 3'd0 : num_stg - 3'd1;
                fac_q    <= factor_cfg;
                str_q    <= stride_cfg;
                stg      <= '0;
            end
            if (stage_adv) stg <= stg + 3'd1;
            if (do_load) begin
                cur_p  <= ld_p;
                cur_s  <= ld_s;
                cur_sp <= ld_sp;
                cnt    <= {{(NW-3){1'b0}}, ld_p};
            end else if (do_step) begin
                cnt <= cnt + {{(NW-3){1'b0}}, cur_p};
            end
            if (do_load || do_step) begin
                nb_e0 <= adv_e0;
                nb_k  <= adv_k;
            end
        end
    end

    // Registered outputs; data holds its last value whenever nothing is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw              <= 1'b0;
            rd_valid        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            rd_factor       <= '0;
            rd_bank_index   <= '0;
            rd_bank_addr    <= '0;
            rd_twdl_numrtr  <= '0;
            rd_twdl_demontr <= '0;
        end else begin
            done     <= finish;
            rd_valid <= do_load || do_step;
            if (do_load || do_step) begin
                rd_factor       <= src_p;
                rd_bank_index   <= lane_idx;
                rd_bank_addr    <= lane_addr;
                rd_twdl_numrtr  <= src_k;
                rd_twdl_demontr <= src_sp;
            end
            if (state == IDLE && start) busy <= 1'b1;
            if (finish) begin
                busy <= 1'b0;
                sw   <= 1'b0;
            end else if (stage_adv) begin
                sw <= ~sw;
            end
        end
    end
endmodule

// File: tb/tb_mrd_rd_addr_ctrl.sv
// Testbench for mrd_rd_addr_ctrl: table vectors for the documented transforms,
// hand sequences for idle/reset/hold corners, random transforms vs a model.
`timescale 1ns/1ps
module tb_mrd_rd_addr_ctrl;
    localparam int MAX_STG = 6;
    localparam int NW      = 11;
    localparam int AW      = 8;
    localparam int W       = 3 + 15 + 5*AW + NW + NW + 1;
    localparam int SW      = MAX_STG*NW;
    localparam int FW      = MAX_STG*3;

    logic              clk = 1'b0;
    logic              rst, start, wr_done;
    logic [NW-1:0]     n_cfg;
    logic [2:0]        num_stg;
    logic [FW-1:0]     factor_cfg;
    logic [SW-1:0]     stride_cfg;
`ifdef MRD_RD_HOLD_EN
    logic              rd_hold;
`endif
    logic              sw, rd_valid, busy, done;
    logic [2:0]        rd_factor;
    logic [14:0]       rd_bank_index;
    logic [5*AW-1:0]   rd_bank_addr;
    logic [NW-1:0]     rd_twdl_numrtr;
    logic [NW:0]       rd_twdl_demontr;
    logic [1:0]        dbg_state;

    mrd_rd_addr_ctrl #(.MAX_STG(MAX_STG), .NW(NW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_cfg(n_cfg), .num_stg(num_stg),
        .factor_cfg(factor_cfg), .stride_cfg(stride_cfg), .wr_done(wr_done),
`ifdef MRD_RD_HOLD_EN
        .rd_hold(rd_hold),
`endif
        .sw(sw), .rd_valid(rd_valid), .rd_factor(rd_factor),
        .rd_bank_index(rd_bank_index), .rd_bank_addr(rd_bank_addr),
        .rd_twdl_numrtr(rd_twdl_numrtr), .rd_twdl_demontr(rd_twdl_demontr),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want summary");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int              n;
        int              f0;
        int              f1;
        logic [2:0]      fac;
        logic [14:0]     idx;
        logic [5*AW-1:0] addr;
        logic [NW-1:0]   num;
        logic [NW:0]     den;
    } vec_t;

    vec_t           tbl[14];
    logic [W-1:0]   exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             done_cnt = 0;
    int             cfg_n, cfg_ns;
    int             cfg_f[MAX_STG];
    int             cfg_s[MAX_STG];
    bit             cfg_ns_zero;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    function automatic logic [W-1:0] dut_pack();
        return {rd_factor, rd_bank_index, rd_bank_addr, rd_twdl_numrtr, rd_twdl_demontr};
    endfunction

    task automatic build_table();
        tbl[0] = '{12, 4, 3, 3'd4, {3'd0, 3'd4, 3'd1, 3'd3, 3'd0}, {8'd0, 8'd1, 8'd1, 8'd0, 8'd0}, 11'd0, 12'd12};
        tbl[1] = '{12, 4, 3, 3'd4, {3'd0, 3'd0, 3'd2, 3'd4, 3'd1}, {8'd0, 8'd2, 8'd1, 8'd0, 8'd0}, 11'd1, 12'd12};
        tbl[2] = '{12, 4, 3, 3'd4, {3'd0, 3'd1, 3'd3, 3'd0, 3'd2}, {8'd0, 8'd2, 8'd1, 8'd1, 8'd0}, 11'd2, 12'd12};
        tbl[3] = '{12, 4, 3, 3'd3, {3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 11'd0, 12'd3};
        tbl[4] = '{12, 4, 3, 3'd3, {3'd0, 3'd0, 3'd0, 3'd4, 3'd3}, {8'd0, 8'd0, 8'd1, 8'd0, 8'd0}, 11'd0, 12'd3};
        tbl[5] = '{12, 4, 3, 3'd3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1}, {8'd0, 8'd0, 8'd1, 8'd1, 8'd1}, 11'd0, 12'd3};
        tbl[6] = '{12, 4, 3, 3'd3, {3'd0, 3'd0, 3'd1, 3'd0, 3'd4}, {8'd0, 8'd0, 8'd2, 8'd2, 8'd1}, 11'd0, 12'd3};
        for (int k = 0; k < 5; k++)
            tbl[7+k] = '{10, 2, 5, 3'd2, {9'd0, 3'(k), 3'(k)}, {24'd0, 8'd1, 8'd0}, 11'(k), 12'd10};
        tbl[12] = '{10, 2, 5, 3'd5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 40'd0, 11'd0, 12'd5};
        tbl[13] = '{10, 2, 5, 3'd5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 11'd0, 12'd5};
    endtask

    task automatic load_table(input int n);
        exp_q.delete();
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].n == n) begin
                cfg_n    = n;
                cfg_ns   = 2;
                cfg_f[0] = tbl[i].f0;
                cfg_f[1] = tbl[i].f1;
                exp_q.push_back({tbl[i].fac, tbl[i].idx, tbl[i].addr, tbl[i].num, tbl[i].den});
            end
        end
        cfg_s[0]    = cfg_n / cfg_f[0];
        cfg_s[1]    = 1;
        cfg_ns_zero = 1'b0;
    endtask

    // Reference model: enumerate butterflies straight from b = g*S + k
    task automatic fill_model();
        logic [14:0]     idx;
        logic [5*AW-1:0] addr;
        int p, s, k, g, e;
        exp_q.delete();
        for (int st = 0; st < cfg_ns; st++) begin
            p = cfg_f[st];
            s = cfg_s[st];
            for (int b = 0; b < cfg_n / p; b++) begin
                k    = b % s;
                g    = b / s;
                idx  = '0;
                addr = '0;
                for (int j = 0; j < p; j++) begin
                    e = g*s*p + k + j*s;
                    idx[3*j +: 3]   = 3'(e % 5);
                    addr[AW*j +: AW] = AW'(e / 5);
                end
                exp_q.push_back({3'(p), idx, addr, NW'(k), (NW+1)'(s*p)});
            end
        end
    endtask

    task automatic gen_random();
        int prod;
        do begin
            cfg_ns = $urandom_range(1, 5);
            prod   = 1;
            for (int s = 0; s < cfg_ns; s++) begin
                cfg_f[s] = $urandom_range(2, 5);
                prod     = prod * cfg_f[s];
            end
        end while (prod > 1200);
        cfg_n = prod;
        for (int s = 0; s < cfg_ns; s++) begin
            prod     = prod / cfg_f[s];
            cfg_s[s] = prod;
        end
        cfg_ns_zero = (cfg_ns == 1) && ($urandom_range(0, 1) == 1);
    endtask

    task automatic drive_cfg();
        n_cfg      = NW'(cfg_n);
        num_stg    = cfg_ns_zero ? 3'd0 : 3'(cfg_ns);
        factor_cfg = '0;
        stride_cfg = '0;
        for (int s = 0; s < cfg_ns; s++) begin
            factor_cfg[3*s +: 3]   = 3'(cfg_f[s]);
            stride_cfg[NW*s +: NW] = NW'(cfg_s[s]);
        end
    endtask

    // Runs one full transform against exp_q; noisy adds ignored start/wr_done/cfg churn
    task automatic run_xform(input bit noisy);
        int cnt, guard, d;
        done_cnt = 0;
        drive_cfg();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int s = 0; s < cfg_ns; s++) begin
            chk("first_valid", rd_valid, 1);
            chk("sw_stage", sw, s % 2);
            cnt   = 0;
            guard = 0;
            while (rd_valid === 1'b1 && guard < 3000) begin
                if (exp_q.size() == 0) chk("exp_avail", exp_q.size(), 1);
                else                   chk("butterfly", dut_pack(), exp_q.pop_front());
                cnt++;
                guard++;
                if (noisy) begin
                    wr_done    = ($urandom_range(0, 3) == 0);
                    start      = ($urandom_range(0, 3) == 0);
                    n_cfg      = NW'($urandom);
                    num_stg    = 3'($urandom);
                    factor_cfg = FW'($urandom);
                    stride_cfg = SW'({$urandom, $urandom, $urandom});
                end
                step();
            end
            wr_done = 1'b0;
            start   = 1'b0;
            chk("valid_count", cnt, cfg_n / cfg_f[s]);
            d = $urandom_range(0, 3);
            repeat (d) begin
                if (noisy) start = ($urandom_range(0, 1) == 1);
                step();
                chk("gap_invalid", rd_valid, 0);
                chk("busy_wait", busy, 1);
            end
            start   = 1'b0;
            wr_done = 1'b1;
            step();
            wr_done = 1'b0;
            if (s < cfg_ns - 1) begin
                chk("sw_toggle", sw, (s + 1) % 2);
                chk("setup_bubble", rd_valid, 0);
                step();
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_end", busy, 0);
                chk("sw_idle", sw, 0);
                chk("end_valid", rd_valid, 0);
                step();
                chk("done_once", done, 0);
            end
        end
        chk("done_count", done_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        wr_done    = 1'b0;
        n_cfg      = '0;
        num_stg    = '0;
        factor_cfg = '0;
        stride_cfg = '0;
`ifdef MRD_RD_HOLD_EN
        rd_hold    = 1'b0;
`endif
        build_table();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sw", sw, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", dut_pack(), 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b0;
        step();

        // Documented vectors
        load_table(12);
        run_xform(1'b0);
        load_table(10);
        run_xform(1'b0);

        // wr_done while idle changes nothing
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_valid", rd_valid, 0);
        chk("idle_state", dbg_state, 0);
        chk("idle_sw", sw, 0);

        // Same vectors with start/wr_done/config churn during busy
        load_table(12);
        run_xform(1'b1);

        // Asynchronous reset in the middle of stage 1
        load_table(12);
        drive_cfg();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("mid_wait", rd_valid, 0);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        step();
        chk("mid_s1_valid", rd_valid, 1);
        chk("mid_s1_sw", sw, 1);
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_sw", sw, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        load_table(12);
        run_xform(1'b0);

`ifdef MRD_RD_HOLD_EN
        // Stall at b=1 of stage 0 for three cycles
        load_table(12);
        drive_cfg();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("hold_b0", dut_pack(), exp_q[0]);
        rd_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_invalid", rd_valid, 0);
            chk("hold_frozen", dut_pack(), exp_q[0]);
        end
        rd_hold = 1'b0;
        step();
        chk("hold_resume_valid", rd_valid, 1);
        chk("hold_b1", dut_pack(), exp_q[1]);
        step();
        chk("hold_b2", dut_pack(), exp_q[2]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
`endif

        // Single radix-5 stage with num_stg = 0
        cfg_n       = 5;
        cfg_ns      = 1;
        cfg_f[0]    = 5;
        cfg_s[0]    = 1;
        cfg_ns_zero = 1'b1;
        fill_model();
        run_xform(1'b0);

        // Random transforms against the model
        for (int r = 0; r < 12; r++) begin
            gen_random();
            fill_model();
            run_xform(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
